// File: rtl/cpu_host_controller_if.sv
// Host command/response link of cpu_host_controller: one command in, one response out.
// The host drives the master modport; the controller sits on the slave modport.
interface cpu_host_controller_if #(
  parameter int WORD_SIZE = 18
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [WORD_SIZE-1:0] cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] rsp_data;
  logic                 rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/cpu_host_controller.sv
// Run-control, code loading and data-memory sharing between a host link and one processor.
// Build macro CPU_CYCLE_COUNTER_EN adds an 18-bit saturating run-cycle counter readable through STATUS.
module cpu_host_controller #(
  parameter int ADDR_SIZE  = 18,
  parameter int WORD_SIZE  = 18,
  parameter bit START_HELD = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  cpu_host_controller_if.slave  host,
  output logic                  cpu_reset,
  input  logic                  cpu_wait_for_continue,
  output logic                  cpu_continue,
  input  logic                  cpu_mem_we,
  input  logic [ADDR_SIZE-1:0]  cpu_mem_addr,
  input  logic [WORD_SIZE-1:0]  cpu_mem_in,
  output logic                  mem_we,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]  mem_in,
  input  logic [WORD_SIZE-1:0]  mem_out,
  output logic                  code_we,
  output logic [ADDR_SIZE-1:0]  code_addr_w,
  output logic [WORD_SIZE-1:0]  code_data_w
);

  typedef enum logic [2:0] {IDLE, CONT, CODE_WR, MEM_WR, MEM_RD, RESP} state_t;
  typedef enum logic [2:0] {
    OP_STATUS, OP_HOLD, OP_RELEASE, OP_CONTINUE,
    OP_SET_PTR, OP_WRITE_CODE, OP_WRITE_MEM, OP_READ_MEM
  } op_t;

  state_t               state, state_next;
  logic                 held, held_next;
  logic [ADDR_SIZE-1:0] ptr, ptr_next;
  logic [WORD_SIZE-1:0] data_reg, data_next;
  logic                 rsp_valid, rsp_valid_next;
  logic                 rsp_err, rsp_err_next;
  logic [WORD_SIZE-1:0] rsp_data, rsp_data_next;
  logic                 cmd_ready;
  logic                 accept;
  logic                 stopped;
  logic                 host_owns;
  op_t                  op;

  assign op        = op_t'(host.cmd_op);
  assign stopped   = held | cpu_wait_for_continue;
  assign cmd_ready = (state == IDLE) & ~rsp_valid;
  assign accept    = host.cmd_valid & cmd_ready;

  assign host.cmd_ready = cmd_ready;
  assign host.rsp_valid = rsp_valid;
  assign host.rsp_err   = rsp_err;
  assign host.rsp_data  = rsp_data;
  assign cpu_reset      = held;

`ifdef CPU_CYCLE_COUNTER_EN
  logic [17:0] cycle_count;
  logic        hold_accept;

  assign hold_accept = accept & (op == OP_HOLD);

  // Counts cycles the processor is actually executing; sticks at all-ones.
  always_ff @(posedge clock) begin
    if (reset || hold_accept) begin
      cycle_count <= '0;
    end else if (!held && !cpu_wait_for_continue && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 18'd1;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      held      <= START_HELD;
      ptr       <= '0;
      data_reg  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_next;
      held      <= held_next;
      ptr       <= ptr_next;
      data_reg  <= data_next;
      rsp_valid <= rsp_valid_next;
      rsp_err   <= rsp_err_next;
      rsp_data  <= rsp_data_next;
    end
  end

  // Short ops answer straight from IDLE; access ops spend one cycle in their own state first.
  always_comb begin
    state_next     = state;
    held_next      = held;
    ptr_next       = ptr;
    data_next      = data_reg;
    rsp_valid_next = rsp_valid;
    rsp_err_next   = rsp_err;
    rsp_data_next  = rsp_data;

    case (state)
      IDLE: begin
        if (accept) begin
          data_next      = host.cmd_data;
          rsp_data_next  = '0;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
          unique case (op)
            OP_STATUS: begin
              if (host.cmd_data[0]) begin
`ifdef CPU_CYCLE_COUNTER_EN
                rsp_data_next = WORD_SIZE'(cycle_count);
`else
                rsp_err_next  = 1'b1;
`endif
              end else begin
                rsp_data_next[1:0] = {held, cpu_wait_for_continue};
              end
            end
            OP_HOLD:    held_next = 1'b1;
            OP_RELEASE: held_next = 1'b0;
            OP_CONTINUE: begin
              if (cpu_wait_for_continue && !held) begin
                state_next     = CONT;
                rsp_valid_next = 1'b0;
              end else begin
                rsp_err_next = 1'b1;
              end
            end
            OP_SET_PTR: ptr_next = host.cmd_data[ADDR_SIZE-1:0];
            OP_WRITE_CODE: begin
              if (held) begin
                state_next     = CODE_WR;
                rsp_valid_next = 1'b0;
              end else begin
                rsp_err_next = 1'b1;
              end
            end
            OP_WRITE_MEM: begin
              if (stopped) begin
                state_next     = MEM_WR;
                rsp_valid_next = 1'b0;
              end else begin
                rsp_err_next = 1'b1;
              end
            end
            OP_READ_MEM: begin
              if (stopped) begin
                state_next     = MEM_RD;
                rsp_valid_next = 1'b0;
              end else begin
                rsp_err_next = 1'b1;
              end
            end
          endcase
        end
      end
      CONT: begin
        state_next     = RESP;
        rsp_valid_next = 1'b1;
      end
      CODE_WR, MEM_WR: begin
        ptr_next       = ptr + ADDR_SIZE'(1);
        state_next     = RESP;
        rsp_valid_next = 1'b1;
      end
      MEM_RD: begin
        rsp_data_next  = mem_out;
        ptr_next       = ptr + ADDR_SIZE'(1);
        state_next     = RESP;
        rsp_valid_next = 1'b1;
      end
      RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write strobes are gated by reset so an aborted access never lands in memory.
  always_comb begin
    host_owns    = ((state == MEM_WR) || (state == MEM_RD)) && !reset;
    mem_we       = host_owns ? (state == MEM_WR) : (cpu_mem_we && !reset);
    mem_addr     = host_owns ? ptr : cpu_mem_addr;
    mem_in       = host_owns ? data_reg : cpu_mem_in;
    code_we      = (state == CODE_WR) && !reset;
    code_addr_w  = ptr;
    code_data_w  = data_reg;
    cpu_continue = (state == CONT) && !reset;
  end

endmodule

// File: tb/tb_cpu_host_controller.sv
// Directed self-checking bench for cpu_host_controller with a small asynchronous-read data memory model.
// Build with CPU_CYCLE_COUNTER_EN defined to exercise the run-cycle counter instead of its rejection.
module tb_cpu_host_controller;

  localparam logic [2:0] OP_STATUS     = 3'd0;
  localparam logic [2:0] OP_HOLD       = 3'd1;
  localparam logic [2:0] OP_RELEASE    = 3'd2;
  localparam logic [2:0] OP_CONTINUE   = 3'd3;
  localparam logic [2:0] OP_SET_PTR    = 3'd4;
  localparam logic [2:0] OP_WRITE_CODE = 3'd5;
  localparam logic [2:0] OP_WRITE_MEM  = 3'd6;
  localparam logic [2:0] OP_READ_MEM   = 3'd7;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_reset;
  logic        cpu_wait_for_continue;
  logic        cpu_continue;
  logic        cpu_mem_we;
  logic [17:0] cpu_mem_addr;
  logic [17:0] cpu_mem_in;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [17:0] mem_in;
  logic [17:0] mem_out;
  logic        code_we;
  logic [17:0] code_addr_w;
  logic [17:0] code_data_w;

  logic [17:0] mem_model [0:63] = '{default: '0};

  int num_checks    = 0;
  int num_fail      = 0;
  int code_we_count = 0;
  int cont_count    = 0;
  int pass_bad      = 0;
  bit pass_on       = 1'b0;
  int snap;

  logic        mid_code_we, mid_mem_we, mid_cont;
  logic [17:0] mid_code_addr, mid_code_data, mid_mem_addr, mid_mem_in;

  cpu_host_controller_if #(.WORD_SIZE(18)) bus ();

  cpu_host_controller #(
    .ADDR_SIZE(18), .WORD_SIZE(18), .START_HELD(1'b1)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .host                  (bus),
    .cpu_reset             (cpu_reset),
    .cpu_wait_for_continue (cpu_wait_for_continue),
    .cpu_continue          (cpu_continue),
    .cpu_mem_we            (cpu_mem_we),
    .cpu_mem_addr          (cpu_mem_addr),
    .cpu_mem_in            (cpu_mem_in),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_in                (mem_in),
    .mem_out               (mem_out),
    .code_we               (code_we),
    .code_addr_w           (code_addr_w),
    .code_data_w           (code_data_w)
  );

  always #5 clock = ~clock;

  // Data memory: combinational read, write on the rising edge.
  assign mem_out = mem_model[mem_addr[5:0]];
  always @(posedge clock) begin
    if (mem_we) mem_model[mem_addr[5:0]] <= mem_in;
  end

  // Pulse counters and passthrough watch, sampled mid-cycle.
  always @(negedge clock) begin
    if (code_we) code_we_count++;
    if (cpu_continue) cont_count++;
    if (pass_on && ((mem_we !== cpu_mem_we) || (mem_addr !== cpu_mem_addr) || (mem_in !== cpu_mem_in)))
      pass_bad++;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    assert (observed === expected) else begin
      num_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full command: accept, optional access cycle, response check, optional stall, handshake.
  task automatic apply_stimulus(input logic [2:0] op, input logic [17:0] data, input bit long_op,
                                input logic [17:0] exp_data, input logic exp_err,
                                input int stall, input string tag);
    check_output({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    if (long_op) begin
      check_output({tag, ".early_rsp"}, 32'(bus.rsp_valid), 32'd0);
      mid_code_we   = code_we;
      mid_code_addr = code_addr_w;
      mid_code_data = code_data_w;
      mid_mem_we    = mem_we;
      mid_mem_addr  = mem_addr;
      mid_mem_in    = mem_in;
      mid_cont      = cpu_continue;
      @(posedge clock); #1;
    end
    check_output({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check_output({tag, ".rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
    check_output({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      check_output({tag, ".stable"}, {12'd0, bus.rsp_valid, bus.rsp_err, bus.cmd_ready, bus.rsp_data},
                   {12'd0, 1'b1, exp_err, 1'b0, exp_data});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    check_output({tag, ".rsp_taken"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    reset                 = 1'b1;
    bus.cmd_valid         = 1'b0;
    bus.cmd_op            = '0;
    bus.cmd_data          = '0;
    bus.rsp_ready         = 1'b0;
    cpu_wait_for_continue = 1'b0;
    cpu_mem_we            = 1'b0;
    cpu_mem_addr          = '0;
    cpu_mem_in            = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    check_output("reset.cpu_reset", 32'(cpu_reset), 32'd1);
    check_output("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("reset.code_we", 32'(code_we), 32'd0);
    check_output("reset.cpu_continue", 32'(cpu_continue), 32'd0);

    apply_stimulus(OP_STATUS, 18'h0, 1'b0, 18'h2, 1'b0, 0, "status_reset");

    // Code load while held.
    apply_stimulus(OP_SET_PTR, 18'h10, 1'b0, 18'h0, 1'b0, 0, "set_ptr_10");
    snap = code_we_count;
    apply_stimulus(OP_WRITE_CODE, 18'h11111, 1'b1, 18'h0, 1'b0, 0, "wcode0");
    check_output("wcode0.we", 32'(mid_code_we), 32'd1);
    check_output("wcode0.addr", 32'(mid_code_addr), 32'h10);
    check_output("wcode0.data", 32'(mid_code_data), 32'h11111);
    apply_stimulus(OP_WRITE_CODE, 18'h22222, 1'b1, 18'h0, 1'b0, 0, "wcode1");
    check_output("wcode1.addr", 32'(mid_code_addr), 32'h11);
    check_output("wcode1.data", 32'(mid_code_data), 32'h22222);
    apply_stimulus(OP_WRITE_CODE, 18'h33333, 1'b1, 18'h0, 1'b0, 0, "wcode2");
    check_output("wcode2.addr", 32'(mid_code_addr), 32'h12);
    check_output("wcode2.data", 32'(mid_code_data), 32'h33333);
    check_output("wcode.pulses", 32'(code_we_count - snap), 32'd3);

    apply_stimulus(OP_RELEASE, 18'h0, 1'b0, 18'h0, 1'b0, 0, "release");
    check_output("release.cpu_reset", 32'(cpu_reset), 32'd0);
    snap = code_we_count;
    apply_stimulus(OP_WRITE_CODE, 18'h44444, 1'b0, 18'h0, 1'b1, 0, "wcode_running");
    check_output("wcode_running.no_we", 32'(code_we_count - snap), 32'd0);

    // Processor running: host memory access rejected, port stays with the processor.
    cpu_mem_we   = 1'b1;
    cpu_mem_addr = 18'h2A;
    cpu_mem_in   = 18'h155;
    pass_on      = 1'b1;
    apply_stimulus(OP_READ_MEM, 18'h0, 1'b0, 18'h0, 1'b1, 0, "rmem_running");
    pass_on      = 1'b0;
    cpu_mem_we   = 1'b0;
    check_output("rmem_running.passthrough", 32'(pass_bad), 32'd0);

    // Processor halted on wait: host owns data memory.
    cpu_wait_for_continue = 1'b1;
    apply_stimulus(OP_STATUS, 18'h0, 1'b0, 18'h1, 1'b0, 0, "status_wait");
    apply_stimulus(OP_SET_PTR, 18'h5, 1'b0, 18'h0, 1'b0, 0, "set_ptr_5a");
    apply_stimulus(OP_WRITE_MEM, 18'h2ABCD, 1'b1, 18'h0, 1'b0, 0, "wmem");
    check_output("wmem.we", 32'(mid_mem_we), 32'd1);
    check_output("wmem.addr", 32'(mid_mem_addr), 32'h5);
    check_output("wmem.in", 32'(mid_mem_in), 32'h2ABCD);
    apply_stimulus(OP_SET_PTR, 18'h5, 1'b0, 18'h0, 1'b0, 0, "set_ptr_5b");
    apply_stimulus(OP_READ_MEM, 18'h0, 1'b1, 18'h2ABCD, 1'b0, 0, "rmem");
    check_output("rmem.we", 32'(mid_mem_we), 32'd0);
    check_output("rmem.addr", 32'(mid_mem_addr), 32'h5);
    apply_stimulus(OP_WRITE_MEM, 18'h00077, 1'b1, 18'h0, 1'b0, 0, "wmem_next");
    check_output("wmem_next.addr", 32'(mid_mem_addr), 32'h6);
    check_output("wmem_next.stored", 32'(mem_model[6]), 32'h77);

    // Continue from wait, then a continue that must be refused.
    snap = cont_count;
    apply_stimulus(OP_CONTINUE, 18'h0, 1'b1, 18'h0, 1'b0, 0, "continue");
    check_output("continue.mid", 32'(mid_cont), 32'd1);
    check_output("continue.pulses", 32'(cont_count - snap), 32'd1);
    cpu_wait_for_continue = 1'b0;
    snap = cont_count;
    apply_stimulus(OP_CONTINUE, 18'h0, 1'b0, 18'h0, 1'b1, 0, "continue_running");
    check_output("continue_running.pulses", 32'(cont_count - snap), 32'd0);

    // Response back-pressure.
    cpu_wait_for_continue = 1'b1;
    apply_stimulus(OP_STATUS, 18'h0, 1'b0, 18'h1, 1'b0, 10, "stall");

    // Reset in the middle of a host write.
    apply_stimulus(OP_SET_PTR, 18'h8, 1'b0, 18'h0, 1'b0, 0, "set_ptr_8");
    check_output("abort.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_WRITE_MEM;
    bus.cmd_data  = 18'h12345;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    check_output("abort.mid_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check_output("abort.we_in_reset", 32'(mem_we), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    check_output("abort.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("abort.cpu_reset", 32'(cpu_reset), 32'd1);
    check_output("abort.not_written", 32'(mem_model[8]), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check_output("abort.no_late_rsp", 32'(bus.rsp_valid), 32'd0);

`ifdef CPU_CYCLE_COUNTER_EN
    apply_stimulus(OP_RELEASE, 18'h0, 1'b0, 18'h0, 1'b0, 0, "cnt_release");
    cpu_wait_for_continue = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    cpu_wait_for_continue = 1'b1;
    apply_stimulus(OP_STATUS, 18'h1, 1'b0, 18'd100, 1'b0, 0, "counter");
    apply_stimulus(OP_HOLD, 18'h0, 1'b0, 18'h0, 1'b0, 0, "cnt_hold");
    apply_stimulus(OP_STATUS, 18'h1, 1'b0, 18'd0, 1'b0, 0, "counter_cleared");
`else
    apply_stimulus(OP_STATUS, 18'h1, 1'b0, 18'h0, 1'b1, 0, "counter_absent");
`endif
    apply_stimulus(OP_STATUS, 18'h0, 1'b0, 18'h3, 1'b0, 0, "status_final");

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cpu_host_controller.md
Name: cpu_host_controller

Overview:
Host-side run-control and memory-sharing controller placed between a host command link and one processor instance with its code and data memories.
- Holds or releases the processor's reset.
- Resumes the processor from `wait` instructions.
- Loads code memory while the processor is held.
- Shares the single data-memory port between processor and host while the processor is stopped.
- One command in, exactly one response out.

Parameters:
- ADDR_SIZE, 18, code/data address width
- WORD_SIZE, 18, data word width
- START_HELD, 1, value of the internal hold flag after reset (1 = processor held in reset)

Ports:
- clock  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset of this block
- cmd_valid  in  1  host command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  command code
- cmd_data  in  WORD_SIZE  command operand
- rsp_valid  out  1  response present
- rsp_ready  in  1  host takes response
- rsp_data  out  WORD_SIZE  response payload
- rsp_err  out  1  command rejected
- cpu_reset  out  1  processor reset, equals hold flag
- cpu_wait_for_continue  in  1  processor stopped on `wait`
- cpu_continue  out  1  processor wait_continue_execution
- cpu_mem_we  in  1  processor data write enable
- cpu_mem_addr  in  ADDR_SIZE  processor data address
- cpu_mem_in  in  WORD_SIZE  processor write data
- mem_we  out  1  to data memory
- mem_addr  out  ADDR_SIZE  to data memory
- mem_in  out  WORD_SIZE  to data memory
- mem_out  in  WORD_SIZE  data memory read data (asynchronous read; also wired directly to the processor)
- code_we  out  1  code memory write enable
- code_addr_w  out  ADDR_SIZE  code memory write address
- code_data_w  out  WORD_SIZE  code memory write data

Behaviour:
- Reset values:
  - held = START_HELD; ptr = 0; state = IDLE.
  - rsp_valid, rsp_err, cpu_continue, code_we = 0; rsp_data = 0.
  - The data-memory port is granted to the processor.
- stopped = held | cpu_wait_for_continue.
- Data-port grant:
  - Host owns the port only in states MEM_RD and MEM_WR.
  - Otherwise mem_* is a combinational passthrough of cpu_mem_*.
- cmd_ready = (state == IDLE) & ~rsp_valid.
- Command accept in IDLE. Ops:
  - 0 STATUS: rsp_data = {0.., held, cpu_wait_for_continue}.
  - 1 HOLD: held <= 1. Response data 0.
  - 2 RELEASE: held <= 0. The processor restarts at ip 0 on the next cycle. Response data 0.
  - 3 CONTINUE:
    - If cpu_wait_for_continue and not held: go to CONT, drive cpu_continue = 1 for exactly one cycle, then respond with data 0.
    - Otherwise respond with err = 1 and no pulse.
  - 4 SET_PTR: ptr <= cmd_data[ADDR_SIZE-1:0]. Response data 0.
  - 5 WRITE_CODE:
    - If held: code_we = 1 for one cycle with code_addr_w = ptr and code_data_w = cmd_data; then ptr++.
    - Otherwise err, no write, ptr unchanged.
  - 6 WRITE_MEM:
    - If stopped: MEM_WR for one cycle with mem_we = 1, mem_addr = ptr, mem_in = cmd_data; then ptr++.
    - Otherwise err, no write, ptr unchanged.
  - 7 READ_MEM:
    - If stopped: MEM_RD for one cycle with mem_addr = ptr and mem_we = 0; capture mem_out at the end of that cycle into rsp_data; then ptr++.
    - Otherwise err, no read, rsp_data = 0.
- Rejected commands respond with err = 1 and rsp_data = 0 unless stated otherwise.
- Latency:
  - Ops 0, 1, 2, 4 and all rejected commands: rsp_valid the cycle after accept.
  - Ops 3, 5, 6, 7: rsp_valid two cycles after accept.
- Response handshake:
  - rsp_valid, rsp_data and rsp_err are held stable until rsp_valid & rsp_ready.
  - No new command is accepted until the response is taken.
- The state machine is IDLE → (CONT | CODE_WR | MEM_WR | MEM_RD) → RESP → IDLE on handshake. Short ops go IDLE → RESP directly.
- ptr wraps from 2^ADDR_SIZE-1 to 0.
- The stopped check is sampled at accept only. Host-access states never coincide with cpu_continue, so the processor cannot leave `wait` during a host access.
- reset asserted mid-operation aborts any access at once: pending response discarded, mem_we/code_we low in the reset cycle, held <= START_HELD.

Optional Feature:
CPU_CYCLE_COUNTER_EN
- Enabled: an 18-bit counter increments each cycle with ~held & ~cpu_wait_for_continue.
  - Saturates at all-ones.
  - Cleared by reset and by HOLD.
  - STATUS with cmd_data[0] = 1 returns the counter value, err = 0.
- Disabled: no counter logic. STATUS with cmd_data[0] = 1 returns data 0, err = 1. STATUS with cmd_data[0] = 0 behaves identically in both builds.

Test Plan:
- After reset: STATUS (cmd_data = 0) → rsp_data = 2 (held = 1), cpu_reset = 1, ptr = 0; the response rises one cycle after accept.
- SET_PTR 0x10, then three WRITE_CODE 0x11111/0x22222/0x33333 → code_we pulses at addresses 0x10, 0x11, 0x12, each response err = 0. RELEASE, then WRITE_CODE → err = 1, no code_we.
- While running (cpu_wait_for_continue = 0, held = 0): READ_MEM → err = 1, mem_* mirrors cpu_mem_* on every cycle.
- Processor halted on `wait`: SET_PTR 5, WRITE_MEM 0x2ABCD, SET_PTR 5, READ_MEM → rsp_data = 0x2ABCD. CONTINUE → exactly one cpu_continue cycle; a CONTINUE issued when not waiting → err = 1.
- Hold rsp_ready = 0 for 10 cycles → rsp_* stable and cmd_ready = 0 throughout. Assert reset during MEM_WR → mem_we low in the reset cycle, no response, cpu_reset = START_HELD.
- With CPU_CYCLE_COUNTER_EN: RELEASE, let the processor run 100 cycles until halted on `wait` → STATUS cmd_data = 1 returns 100. Without the macro the same command → err = 1.
